// File: rtl/hazard_unit.sv
// Stall and forwarding control for the 5-stage MIPS pipeline, driven by Tuse/Tnew timing.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_unit #(
  parameter int TNEW_W = 3,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_tuse_rs0,
  input  logic              d_tuse_rs1,
  input  logic              d_tuse_rt0,
  input  logic              d_tuse_rt1,
  input  logic              d_tuse_rt2,
  input  logic              d_regwrite,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [1:0]        fwd_m_rt,
  output logic [31:0]       stall_cnt
);

  localparam logic [1:0] FWD_GRF   = 2'd0;
  localparam logic [1:0] FWD_M     = 2'd1;
  localparam logic [1:0] FWD_W     = 2'd2;
  localparam logic [1:0] FWD_E_PC8 = 2'd3;

  logic [REG_AW-1:0] e_rs_q, e_rt_q, e_a3_q, m_rt_q, m_a3_q, w_a3_q;
  logic [REG_AW-1:0] e_rs_d, e_rt_d, e_a3_d, m_rt_d, m_a3_d, w_a3_d;
  logic [TNEW_W-1:0] e_tnew_q, m_tnew_q, e_tnew_d, m_tnew_d;
  logic              e_we_q, m_we_q, w_we_q, e_we_d, m_we_d, w_we_d;

  logic              rs_used, rt_used, stall_rs, stall_rt;
  logic [TNEW_W-1:0] tuse_rs, tuse_rt;

  // Register $0 is hardwired, so it never produces a dependency.
  function automatic logic hit(input logic we, input logic [REG_AW-1:0] a3,
                               input logic [REG_AW-1:0] src);
    return we && (a3 == src) && (src != '0);
  endfunction

  function automatic logic [1:0] sel_d(input logic [REG_AW-1:0] src,
                                       input logic e_we, input logic [REG_AW-1:0] e_a3,
                                       input logic [TNEW_W-1:0] e_tnew,
                                       input logic m_we, input logic [REG_AW-1:0] m_a3,
                                       input logic [TNEW_W-1:0] m_tnew,
                                       input logic w_we, input logic [REG_AW-1:0] w_a3);
    if (hit(e_we, e_a3, src))      return (e_tnew == '0) ? FWD_E_PC8 : FWD_GRF;
    else if (hit(m_we, m_a3, src)) return (m_tnew == '0) ? FWD_M : FWD_GRF;
    else if (hit(w_we, w_a3, src)) return FWD_W;
    else                           return FWD_GRF;
  endfunction

  function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] src,
                                       input logic m_we, input logic [REG_AW-1:0] m_a3,
                                       input logic [TNEW_W-1:0] m_tnew,
                                       input logic w_we, input logic [REG_AW-1:0] w_a3);
    if (hit(m_we, m_a3, src))      return (m_tnew == '0) ? FWD_M : FWD_GRF;
    else if (hit(w_we, w_a3, src)) return FWD_W;
    else                           return FWD_GRF;
  endfunction

  // D stage: Tuse decode and stall detection against the in-flight producers
  always_comb begin
    rs_used  = d_tuse_rs0 | d_tuse_rs1;
    tuse_rs  = d_tuse_rs0 ? TNEW_W'(0) : TNEW_W'(1);
    rt_used  = d_tuse_rt0 | d_tuse_rt1 | d_tuse_rt2;
    tuse_rt  = d_tuse_rt0 ? TNEW_W'(0) : (d_tuse_rt1 ? TNEW_W'(1) : TNEW_W'(2));
    stall_rs = rs_used &&
               ((hit(e_we_q, e_a3_q, d_rs) && (e_tnew_q > tuse_rs)) ||
                (hit(m_we_q, m_a3_q, d_rs) && (m_tnew_q > tuse_rs)));
    stall_rt = rt_used &&
               ((hit(e_we_q, e_a3_q, d_rt) && (e_tnew_q > tuse_rt)) ||
                (hit(m_we_q, m_a3_q, d_rt) && (m_tnew_q > tuse_rt)));
    stall    = stall_rs | stall_rt;
  end

  always_comb begin
    fwd_d_rs = sel_d(d_rs, e_we_q, e_a3_q, e_tnew_q, m_we_q, m_a3_q, m_tnew_q, w_we_q, w_a3_q);
    fwd_d_rt = sel_d(d_rt, e_we_q, e_a3_q, e_tnew_q, m_we_q, m_a3_q, m_tnew_q, w_we_q, w_a3_q);
    fwd_e_rs = sel_e(e_rs_q, m_we_q, m_a3_q, m_tnew_q, w_we_q, w_a3_q);
    fwd_e_rt = sel_e(e_rt_q, m_we_q, m_a3_q, m_tnew_q, w_we_q, w_a3_q);
    fwd_m_rt = hit(w_we_q, w_a3_q, m_rt_q) ? FWD_W : FWD_GRF;
  end

  // D -> E boundary: a stall injects a bubble
  always_comb begin
    e_rs_d   = stall ? '0 : d_rs;
    e_rt_d   = stall ? '0 : d_rt;
    e_a3_d   = stall ? '0 : d_a3;
    e_tnew_d = stall ? '0 : d_tnew;
    e_we_d   = stall ? 1'b0 : d_regwrite;
    m_rt_d   = e_rt_q;
    m_a3_d   = e_a3_q;
    m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TNEW_W'(1);
    m_we_d   = e_we_q;
    w_a3_d   = m_a3_q;
    w_we_d   = m_we_q;
  end

  // E -> M -> W boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_a3_q   <= '0;
      e_tnew_q <= '0;
      e_we_q   <= 1'b0;
      m_rt_q   <= '0;
      m_a3_q   <= '0;
      m_tnew_q <= '0;
      m_we_q   <= 1'b0;
      w_a3_q   <= '0;
      w_we_q   <= 1'b0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      e_we_q   <= e_we_d;
      m_rt_q   <= m_rt_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      m_we_q   <= m_we_d;
      w_a3_q   <= w_a3_d;
      w_we_q   <= w_we_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall_cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
